// File: rtl/vga_term_writer.sv
// vga_term_writer: terminal-style writer feeding the vga_model character-cell
// write port. Consumes an ASCII byte stream over a valid/ready handshake, keeps a
// text cursor, interprets CR/LF/BS and issues one cell write per printable byte.
//
// Optional feature macro: VGA_TERM_CLEAR_EN
//   defined   -> reset exits into a screen-clear sweep and byte 0x0C (FF) triggers
//                the same sweep.
//   undefined -> no clear sweep; 0x0C is ignored and busy is tied low.
//
// Ports:
//   clk         pixel clock, all logic on posedge
//   reset       synchronous, active-high
//   in_char     ASCII byte
//   in_valid    in_char valid
//   in_ready    block can accept (transfer = in_valid & in_ready)
//   wr_en       vga_model write_enable
//   addr_write  vga_model cell address (cursor_y*COLS + cursor_x)
//   char_write  vga_model character code
//   cursor_x    current column
//   cursor_y    current row
//   busy        clear sweep in progress
module vga_term_writer #(
   parameter int unsigned COLS       = 160,
   parameter int unsigned ROWS       = 128,
   parameter int unsigned ADDR_WIDTH = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              in_char,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    wr_en,
   output logic [ADDR_WIDTH-1:0]   addr_write,
   output logic [7:0]              char_write,
   output logic [$clog2(COLS)-1:0] cursor_x,
   output logic [$clog2(ROWS)-1:0] cursor_y,
   output logic                    busy
);

   localparam int unsigned XW    = $clog2(COLS);
   localparam int unsigned YW    = $clog2(ROWS);
   localparam int unsigned CELLS = COLS * ROWS;

   localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;
`ifdef VGA_TERM_CLEAR_EN
   localparam logic [7:0] CH_FF    = 8'h0C;
   // One extra bit so the sweep counter can hold CELLS as its terminal value.
   localparam int unsigned CW      = ADDR_WIDTH + 1;
`endif

   // The last cell address must be representable on addr_write.
   generate
      if (longint'(CELLS) > (longint'(1) << ADDR_WIDTH)) begin : g_addr_too_narrow
         $error("vga_term_writer: COLS*ROWS-1 does not fit in ADDR_WIDTH bits");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t state;

`ifdef VGA_TERM_CLEAR_EN
   logic [CW-1:0] clr_cnt;
`endif

   logic [ADDR_WIDTH-1:0] cell_addr;
   logic [YW-1:0]         row_next;
   logic [XW-1:0]         adv_x;
   logic [YW-1:0]         adv_y;
   logic                  transfer;
   logic                  printable;

   // Cursor arithmetic: current cell address and the advanced cursor position.
   always_comb begin
      cell_addr = ADDR_WIDTH'(ADDR_WIDTH'(cursor_y) * ADDR_WIDTH'(COLS))
                  + ADDR_WIDTH'(cursor_x);
      row_next  = (cursor_y == Y_LAST) ? '0 : cursor_y + YW'(1);
      adv_x     = cursor_x;
      adv_y     = cursor_y;
      if (cursor_x == X_LAST) begin
         adv_x = '0;
         adv_y = row_next;
      end else begin
         adv_x = cursor_x + XW'(1);
      end
      transfer  = in_valid & in_ready;
      printable = (in_char >= CH_SPACE) && (in_char <= CH_TILDE);
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en      <= 1'b0;
         addr_write <= '0;
         char_write <= '0;
         cursor_x   <= '0;
         cursor_y   <= '0;
`ifdef VGA_TERM_CLEAR_EN
         state      <= ST_CLEAR;
         in_ready   <= 1'b0;
         busy       <= 1'b1;
         clr_cnt    <= '0;
`else
         state      <= ST_RUN;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
`endif
      end else begin
         wr_en <= 1'b0;
         case (state)
            ST_RUN: begin
               if (transfer) begin
                  if (printable) begin
                     wr_en      <= 1'b1;
                     addr_write <= cell_addr;
                     char_write <= in_char;
                     cursor_x   <= adv_x;
                     cursor_y   <= adv_y;
                  end else if (in_char == CH_LF) begin
                     cursor_x <= '0;
                     cursor_y <= row_next;
                  end else if (in_char == CH_CR) begin
                     cursor_x <= '0;
                  end else if (in_char == CH_BS) begin
                     // Backspace at column 0 is a no-op.
                     if (cursor_x != '0) begin
                        cursor_x   <= cursor_x - XW'(1);
                        wr_en      <= 1'b1;
                        addr_write <= cell_addr - ADDR_WIDTH'(1);
                        char_write <= CH_SPACE;
                     end
`ifdef VGA_TERM_CLEAR_EN
                  end else if (in_char == CH_FF) begin
                     state    <= ST_CLEAR;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                     clr_cnt  <= '0;
`endif
                  end
               end
            end
            ST_CLEAR: begin
`ifdef VGA_TERM_CLEAR_EN
               // Sweep every cell with a space; the terminal count adds one idle
               // cycle so in_ready stays low while the last write is presented.
               if (clr_cnt == CW'(CELLS)) begin
                  state    <= ST_RUN;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  cursor_x <= '0;
                  cursor_y <= '0;
               end else begin
                  wr_en      <= 1'b1;
                  addr_write <= ADDR_WIDTH'(clr_cnt);
                  char_write <= CH_SPACE;
                  clr_cnt    <= clr_cnt + CW'(1);
               end
`else
               state    <= ST_RUN;
               in_ready <= 1'b1;
               busy     <= 1'b0;
`endif
            end
            default: begin
               state    <= ST_RUN;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_term_writer.sv
// tb_vga_term_writer: scoreboard bench for vga_term_writer. Stimulus pushes the
// expected cell writes into a queue; monitors pop and compare on every wr_en.
module tb_vga_term_writer;

`ifdef VGA_TERM_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [7:0]  in_char;
   logic        in_valid;
   logic        in_ready;
   logic        wr_en;
   logic [14:0] addr_write;
   logic [7:0]  char_write;
   logic [7:0]  cursor_x;
   logic [6:0]  cursor_y;
   logic        busy;
   logic        cur_ready;
   bit          use_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  ch;
   } wr_t;

   wr_t exp_q[$];
   wr_t exp2_q[$];

   vga_term_writer #(.COLS(160), .ROWS(128), .ADDR_WIDTH(15)) u_dut (
      .clk(clk), .reset(reset), .in_char(in_char), .in_valid(in_valid),
      .in_ready(in_ready), .wr_en(wr_en), .addr_write(addr_write),
      .char_write(char_write), .cursor_x(cursor_x), .cursor_y(cursor_y),
      .busy(busy)
   );

`ifdef VGA_TERM_CLEAR_EN
   logic       rst2;
   logic       in_ready_c;
   logic       wr_en_c;
   logic [2:0] addr_c;
   logic [7:0] char_c;
   logic [1:0] cx_c;
   logic [0:0] cy_c;
   logic       busy_c;

   vga_term_writer #(.COLS(4), .ROWS(2), .ADDR_WIDTH(3)) u_clr (
      .clk(clk), .reset(rst2), .in_char(in_char), .in_valid(in_valid),
      .in_ready(in_ready_c), .wr_en(wr_en_c), .addr_write(addr_c),
      .char_write(char_c), .cursor_x(cx_c), .cursor_y(cy_c), .busy(busy_c)
   );
   assign cur_ready = use_clr ? in_ready_c : in_ready;

   always @(negedge clk) begin
      wr_t e;
      if (wr_en_c === 1'b1) begin
         if (exp2_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL clr_unexpected_write: got addr %0d char %0h, none expected",
                     addr_c, char_c);
         end else begin
            e = exp2_q.pop_front();
            check("clr_write_addr", 32'(addr_c), e.addr);
            check("clr_write_char", 32'(char_c), 32'(e.ch));
         end
      end
   end
`else
   assign cur_ready = in_ready;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Main-DUT monitor; clear-sweep writes (busy high) are outside this scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (wr_en === 1'b1 && busy !== 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %0d char %0h, none expected",
                     addr_write, char_write);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(addr_write), e.addr);
            check("write_char", 32'(char_write), 32'(e.ch));
         end
      end
   end

   task automatic push(input int a, input logic [7:0] c);
      exp_q.push_back(wr_t'{32'(a), c});
   endtask

   task automatic push2(input int a, input logic [7:0] c);
      exp2_q.push_back(wr_t'{32'(a), c});
   endtask

   // Called at a negedge; returns at the negedge after the byte is transferred.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      while (cur_ready !== 1'b1 && n < 30000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30000) check("in_ready_timeout", 32'(cur_ready), 32'd1);
      in_char  = b;
      in_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic stop();
      in_valid = 1'b0;
   endtask

   task automatic check_cursor(input string name, input int x, input int y);
      check({name, "_x"}, 32'(cursor_x), 32'(x));
      check({name, "_y"}, 32'(cursor_y), 32'(y));
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_char  = 8'h00;
`ifdef VGA_TERM_CLEAR_EN
      rst2     = 1'b1;
`endif
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_addr", 32'(addr_write), 32'd0);
      check("rst_char", 32'(char_write), 32'd0);
      check_cursor("rst_cursor", 0, 0);
      check("rst_in_ready", 32'(in_ready), CLR ? 32'd0 : 32'd1);
      check("rst_busy", 32'(busy), CLR ? 32'd1 : 32'd0);
      reset = 1'b0;

      // 'A','B' back to back
      push(0, 8'h41); push(1, 8'h42);
      send(8'h41); send(8'h42);
      check_cursor("ab_cursor", 2, 0);
      send(8'h0D);
      check("cr_no_write", 32'(wr_en), 32'd0);
      check_cursor("cr_cursor", 0, 0);

      // 159 printables then 'Z' wraps to the next row
      for (int i = 0; i < 159; i++) begin
         push(i, 8'h2E);
         send(8'h2E);
      end
      push(159, 8'h5A); send(8'h5A);
      check_cursor("line_wrap", 0, 1);
      push(160, 8'h79); send(8'h79);
      check_cursor("row1_next", 1, 1);

      // Move to (159,127) and print 'Q' to wrap the whole screen
      send(8'h0D);
      repeat (126) send(8'h0A);
      check_cursor("lf_bottom", 0, 127);
      for (int i = 0; i < 159; i++) begin
         push(20320 + i, 8'h2B);
         send(8'h2B);
      end
      check_cursor("last_cell", 159, 127);
      push(20479, 8'h51); send(8'h51);
      check_cursor("screen_wrap", 0, 0);
      push(0, 8'h52); send(8'h52);

      // Backspace
      send(8'h0D);
      push(0, 8'h41); push(1, 8'h42); push(1, 8'h20);
      send(8'h41); send(8'h42); send(8'h08);
      check_cursor("bs_cursor", 1, 0);
      push(0, 8'h20); send(8'h08);
      check_cursor("bs_col0", 0, 0);
      send(8'h08);
      check("bs_at0_no_write", 32'(wr_en), 32'd0);
      check_cursor("bs_at0_cursor", 0, 0);

      // "ab",CR,LF,'c'
      push(0, 8'h61); push(1, 8'h62);
      send(8'h61); send(8'h62);
      send(8'h0D);
      check("crlf_cr_wr_en", 32'(wr_en), 32'd0);
      send(8'h0A);
      check("crlf_lf_wr_en", 32'(wr_en), 32'd0);
      push(160, 8'h63); send(8'h63);
      stop();
      @(negedge clk);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check("idle_addr_hold", 32'(addr_write), 32'd160);
      check("idle_char_hold", 32'(char_write), 32'h63);
      check_cursor("crlf_cursor", 1, 1);

      // Other control/non-ASCII bytes are consumed without effect
`ifndef VGA_TERM_CLEAR_EN
      send(8'h0C);
      check("ff_ignored_wr_en", 32'(wr_en), 32'd0);
      check("ff_ignored_ready", 32'(in_ready), 32'd1);
      check("ff_ignored_busy", 32'(busy), 32'd0);
`endif
      send(8'h01); send(8'h7F); send(8'h80);
      stop();
      @(negedge clk);
      check_cursor("ignored_cursor", 1, 1);

      // Reset coinciding with a transfer drops the write and homes the cursor
      in_char  = 8'h58;
      in_valid = 1'b1;
      reset    = 1'b1;
      @(negedge clk);
      stop();
      check("rst_mid_wr_en", 32'(wr_en), 32'd0);
      check_cursor("rst_mid_cursor", 0, 0);
      @(negedge clk);

`ifdef VGA_TERM_CLEAR_EN
      // Clear sweep on a 4x2 screen; main DUT stays in reset from here on
      use_clr = 1'b1;
      for (int i = 0; i < 8; i++) push2(i, 8'h20);
      rst2 = 1'b0;
      check("clr_rst_busy", 32'(busy_c), 32'd1);
      check("clr_rst_ready", 32'(in_ready_c), 32'd0);
      for (int n = 0; n < 50 && in_ready_c !== 1'b1; n++) @(negedge clk);
      check("clr_boot_done", 32'(in_ready_c), 32'd1);
      check("clr_boot_queue", 32'(exp2_q.size()), 32'd0);

      push2(0, 8'h61); push2(1, 8'h62);
      for (int i = 0; i < 8; i++) push2(i, 8'h20);
      send(8'h61); send(8'h62); send(8'h0C);
      stop();
      for (int i = 0; i < 9; i++) begin
         check("clr_ready_low", 32'(in_ready_c), 32'd0);
         @(negedge clk);
      end
      check("clr_ready_back", 32'(in_ready_c), 32'd1);
      check("clr_busy_clear", 32'(busy_c), 32'd0);
      check("clr_cursor_x", 32'(cx_c), 32'd0);
      check("clr_cursor_y", 32'(cy_c), 32'd0);
      check("clr_ff_queue", 32'(exp2_q.size()), 32'd0);

      // Reset at the third sweep write restarts from address 0
      push2(0, 8'h20); push2(1, 8'h20); push2(2, 8'h20);
      rst2 = 1'b1;
      @(negedge clk); @(negedge clk);
      rst2 = 1'b0;
      for (int n = 0; n < 50 && !(wr_en_c === 1'b1 && addr_c == 3'd2); n++) @(negedge clk);
      check("clr_third_write_seen", 32'(addr_c), 32'd2);
      rst2 = 1'b1;
      @(negedge clk);
      check("clr_rst_drop", 32'(wr_en_c), 32'd0);
      for (int i = 0; i < 8; i++) push2(i, 8'h20);
      rst2 = 1'b0;
      for (int n = 0; n < 50 && in_ready_c !== 1'b1; n++) @(negedge clk);
      check("clr_restart_done", 32'(in_ready_c), 32'd1);
      check("clr_restart_queue", 32'(exp2_q.size()), 32'd0);
      check("clr_restart_cx", 32'(cx_c), 32'd0);
`endif

      check("main_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
